// File: rtl/opl_timer_bank.sv
// Bank of OPL-style interval timers with per-timer prescaler, preset reload,
// maskable overflow flags and a shared active-low interrupt.
module opl_timer_bank #(
  parameter int NUM_TIMERS     = 2,
  parameter int TIMER_WIDTH    = 8,
  parameter int PRESCALE0      = 4,
  parameter int PRESCALE_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             ic_n,
  input  logic                             sample_clk_en,
  input  logic [NUM_TIMERS-1:0]            preset_wr,
  input  logic [TIMER_WIDTH-1:0]           preset_data,
  input  logic                             ctrl_wr,
  input  logic [2*NUM_TIMERS:0]            ctrl_data,
  input  logic                             force_timer_overflow,
  output logic [NUM_TIMERS:0]              status,
  output logic                             irq_n,
  output logic [NUM_TIMERS*TIMER_WIDTH-1:0] dbg_counter,
  output logic [NUM_TIMERS-1:0]            dbg_run
);

  function automatic int prescale_of(input int idx);
    int p;
    p = PRESCALE0;
    for (int k = 0; k < idx; k++) p = p * PRESCALE_RATIO;
    return p;
  endfunction

  localparam int PRESC_MAX = prescale_of(NUM_TIMERS - 1);
  localparam int PW        = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;

  // Valid/ready does not apply here: every strobe is a single-cycle write
  // accepted unconditionally on the clock edge where it is high.
  logic                  irq_rst;
  logic                  ctrl_run_wr;
  logic                  flag_clr_all;
  logic [NUM_TIMERS-1:0] flag_vec;

  assign irq_rst      = ctrl_data[2*NUM_TIMERS];
  assign ctrl_run_wr  = ctrl_wr & ~irq_rst;
  assign flag_clr_all = ctrl_wr & irq_rst;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : gen_timer
    localparam int            P     = prescale_of(g);
    localparam logic [PW-1:0] PLAST = PW'(P - 1);

    logic [TIMER_WIDTH-1:0] preset_q, preset_d;
    logic [TIMER_WIDTH-1:0] counter_q, counter_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   run_q, run_d;
    logic                   mask_q, mask_d;
    logic                   flag_q, flag_d;
    logic                   tick;
    logic                   ovf;

    always_ff @(posedge clk) begin
      if (!ic_n) begin
        preset_q  <= '0;
        counter_q <= '0;
        presc_q   <= '0;
        run_q     <= 1'b0;
        mask_q    <= 1'b0;
        flag_q    <= 1'b0;
      end else begin
        preset_q  <= preset_d;
        counter_q <= counter_d;
        presc_q   <= presc_d;
        run_q     <= run_d;
        mask_q    <= mask_d;
        flag_q    <= flag_d;
      end
    end

    always_comb begin
      preset_d  = preset_wr[g] ? preset_data : preset_q;
      run_d     = ctrl_run_wr ? ctrl_data[g] : run_q;
      mask_d    = ctrl_run_wr ? ctrl_data[NUM_TIMERS+g] : mask_q;
      counter_d = counter_q;
      presc_d   = presc_q;
      tick      = 1'b0;
      ovf       = 1'b0;
      // Reloads read preset_q, so a preset written on the same cycle waits.
      if (run_d && !run_q) begin
        counter_d = preset_q;
        presc_d   = '0;
      end else if (run_d && run_q && sample_clk_en) begin
        if (presc_q == PLAST) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (tick) begin
          if (force_timer_overflow || (counter_q == '1)) begin
            ovf       = 1'b1;
            counter_d = preset_q;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
    end

    // Clears are applied after the set so mask and irq_rst win over overflow.
    always_comb begin
      flag_d = flag_q;
      if (ovf) flag_d = 1'b1;
      if (mask_d || flag_clr_all) flag_d = 1'b0;
    end

    assign flag_vec[g]                               = flag_q;
    assign dbg_run[g]                                = run_q;
    assign dbg_counter[g*TIMER_WIDTH +: TIMER_WIDTH] = counter_q;
  end

  assign status = {|flag_vec, flag_vec};
  assign irq_n  = ~|flag_vec;

endmodule

// File: tb/tb_opl_timer_bank.sv
// Directed bench for opl_timer_bank at N=2, W=8: a per-cycle vector table
// plus hand-built sequences for masking, force overflow and reset priority.
module tb_opl_timer_bank;

  logic        clk = 1'b0;
  logic        ic_n;
  logic        sample_clk_en;
  logic [1:0]  preset_wr;
  logic [7:0]  preset_data;
  logic        ctrl_wr;
  logic [4:0]  ctrl_data;
  logic        force_timer_overflow;
  logic [2:0]  status;
  logic        irq_n;
  logic [15:0] dbg_counter;
  logic [1:0]  dbg_run;

  int checks = 0;
  int errors = 0;

  opl_timer_bank #(
    .NUM_TIMERS(2), .TIMER_WIDTH(8), .PRESCALE0(4), .PRESCALE_RATIO(4)
  ) dut (
    .clk                  (clk),
    .ic_n                 (ic_n),
    .sample_clk_en        (sample_clk_en),
    .preset_wr            (preset_wr),
    .preset_data          (preset_data),
    .ctrl_wr              (ctrl_wr),
    .ctrl_data            (ctrl_data),
    .force_timer_overflow (force_timer_overflow),
    .status               (status),
    .irq_n                (irq_n),
    .dbg_counter          (dbg_counter),
    .dbg_run              (dbg_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       n;
    logic       sen;
    logic       frc;
    logic [1:0] pwr;
    logic [7:0] pdata;
    logic       cwr;
    logic [4:0] cdata;
    logic [2:0] exp_status;
    logic       exp_irq_n;
    logic [7:0] exp_c0;
    logic [7:0] exp_c1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic n, input logic sen, input logic frc,
                              input logic [1:0] pwr, input logic [7:0] pdata,
                              input logic cwr, input logic [4:0] cdata,
                              input logic [2:0] st, input logic [7:0] c0,
                              input logic [7:0] c1);
    vec_t v;
    v.n = n; v.sen = sen; v.frc = frc; v.pwr = pwr; v.pdata = pdata;
    v.cwr = cwr; v.cdata = cdata; v.exp_status = st;
    v.exp_irq_n = (st[1:0] == 2'b00); v.exp_c0 = c0; v.exp_c1 = c1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    ic_n = v.n; sample_clk_en = v.sen; force_timer_overflow = v.frc;
    preset_wr = v.pwr; preset_data = v.pdata; ctrl_wr = v.cwr; ctrl_data = v.cdata;
    @(posedge clk);
    #1;
    check({tag, " status"}, 32'(status), 32'(v.exp_status));
    check({tag, " irq_n"}, 32'(irq_n), 32'(v.exp_irq_n));
    check({tag, " cnt0"}, 32'(dbg_counter[7:0]), 32'(v.exp_c0));
    check({tag, " cnt1"}, 32'(dbg_counter[15:8]), 32'(v.exp_c1));
  endtask

  initial begin
    logic [7:0] c0;
    logic [2:0] st;
    int         pos;

    ic_n = 1'b0; sample_clk_en = 1'b0; preset_wr = '0; preset_data = '0;
    ctrl_wr = 1'b0; ctrl_data = '0; force_timer_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset beats writes; T0 counts from 0xFE with a flag clear and a preset
    // write landing on reload cycles; then stop/freeze and restart.
    vecs.push_back(mk(0, 1, 1, 2'b11, 8'h55, 1, 5'h03, 3'b000, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 0, 2'b01, 8'hFE, 0, 5'h00, 3'b000, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h01, 3'b000, 8'hFE, 8'h00));
    for (int p = 1; p <= 32; p++) begin
      pos = (p - 1) % 8 + 1;
      c0  = (pos >= 4 && pos <= 7) ? 8'hFF : ((p == 32) ? 8'h80 : 8'hFE);
      st  = (p == 8 || p >= 24) ? 3'b101 : 3'b000;
      if (p == 5) vecs.push_back(mk(1, 0, 0, 2'b00, 8'h00, 0, 5'h00, 3'b000, 8'hFF, 8'h00));
      if (p == 9 || p == 16)
        vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h10, st, c0, 8'h00));
      else if (p == 24)
        vecs.push_back(mk(1, 1, 0, 2'b01, 8'h80, 0, 5'h00, st, c0, 8'h00));
      else
        vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 0, 5'h00, st, c0, 8'h00));
    end
    vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h00, 3'b101, 8'h80, 8'h00));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 0, 5'h00, 3'b101, 8'h80, 8'h00));
    vecs.push_back(mk(1, 1, 0, 2'b01, 8'h40, 0, 5'h00, 3'b101, 8'h80, 8'h00));
    vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h01, 3'b101, 8'h40, 8'h00));

    foreach (vecs[i]) apply(vecs[i], $sformatf("tbl[%0d]", i));

    // T1 masked at preset 0xFF: silent overflows every 16 pulses, then unmask
    // one pulse before the third overflow to prove the 16-pulse period.
    apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 5'h00, 3'b000, 8'h00, 8'h00), "t1 rst");
    apply(mk(1, 0, 0, 2'b10, 8'hFF, 0, 5'h00, 3'b000, 8'h00, 8'h00), "t1 preset");
    apply(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h0A, 3'b000, 8'h00, 8'hFF), "t1 start");
    for (int k = 1; k <= 48; k++)
      apply(mk(1, 1, 0, 2'b00, 8'h00, (k == 47), (k == 47) ? 5'h02 : 5'h00,
               (k == 48) ? 3'b110 : 3'b000, 8'h00, 8'hFF), $sformatf("t1 p%0d", k));

    // Force overflow from preset 0x00, then a plain tick to 0x01 and a forced
    // overflow from 0x01.
    apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 5'h00, 3'b000, 8'h00, 8'h00), "frc rst");
    apply(mk(1, 0, 0, 2'b01, 8'h00, 0, 5'h00, 3'b000, 8'h00, 8'h00), "frc preset");
    apply(mk(1, 1, 1, 2'b00, 8'h00, 1, 5'h01, 3'b000, 8'h00, 8'h00), "frc start");
    for (int k = 1; k <= 12; k++)
      apply(mk(1, 1, (k <= 4 || k == 12), 2'b00, 8'h00, (k == 5), (k == 5) ? 5'h10 : 5'h00,
               (k == 4 || k == 12) ? 3'b101 : 3'b000,
               (k >= 8 && k <= 11) ? 8'h01 : 8'h00, 8'h00), $sformatf("frc p%0d", k));

    // Both flags set, mask T0 clears only flag0, then reset mid-count.
    apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 5'h00, 3'b000, 8'h00, 8'h00), "rst0");
    apply(mk(1, 0, 0, 2'b11, 8'hFF, 0, 5'h00, 3'b000, 8'h00, 8'h00), "both preset");
    apply(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h03, 3'b000, 8'hFF, 8'hFF), "both start");
    for (int k = 1; k <= 20; k++) begin
      if (k >= 19)      st = 3'b110;
      else if (k >= 16) st = 3'b111;
      else if (k >= 4)  st = 3'b101;
      else              st = 3'b000;
      apply(mk(1, 1, 0, 2'b00, 8'h00, (k == 19), (k == 19) ? 5'h07 : 5'h00,
               st, 8'hFF, 8'hFF), $sformatf("both p%0d", k));
    end
    apply(mk(0, 1, 1, 2'b11, 8'h12, 1, 5'h03, 3'b000, 8'h00, 8'h00), "midrst");
    for (int k = 1; k <= 40; k++)
      apply(mk(1, 1, 0, 2'b00, 8'h00, 0, 5'h00, 3'b000, 8'h00, 8'h00), $sformatf("post p%0d", k));
    check("post run", 32'(dbg_run), 32'd0);
    apply(mk(1, 1, 0, 2'b00, 8'h00, 1, 5'h01, 3'b000, 8'h00, 8'h00), "re start");
    for (int k = 1; k <= 4; k++)
      apply(mk(1, 1, 0, 2'b00, 8'h00, 0, 5'h00, 3'b000, (k == 4) ? 8'h01 : 8'h00, 8'h00),
            $sformatf("re p%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
